// File: rtl/hazard_pkg.sv
// Shared types and constants for the hazard/forwarding controller.
// Scoreboard fields are sized for the largest supported AW (8) and NUM_STAGES (15).
package hazard_pkg;

  localparam int SB_AW = 8;
  localparam int SB_VW = 4;

  localparam logic [SB_VW-1:0] FWD_RF    = 4'd0;
  localparam logic [SB_VW-1:0] AVAIL_EX  = 4'd1;
  localparam logic [SB_VW-1:0] AVAIL_MEM = 4'd2;

  typedef logic [SB_VW-1:0] fwd_sel_t;

  typedef struct packed {
    logic             valid;
    logic             wr_en;
    logic [SB_AW-1:0] dst;
    logic [SB_VW-1:0] avail;
  } sb_entry_t;

  localparam int SB_EW = $bits(sb_entry_t);

  // Register 0 is hard-wired, so writes to it are stored as non-writing entries.
  function automatic sb_entry_t make_entry(input logic             valid,
                                           input logic             wr_en,
                                           input logic [SB_AW-1:0] dst,
                                           input logic [SB_VW-1:0] avail);
    sb_entry_t e;
    e.valid = valid;
    e.wr_en = wr_en && (dst != '0);
    e.dst   = dst;
    e.avail = avail;
    return e;
  endfunction

endpackage

// File: rtl/fwd_match.sv
// Per-operand forwarding: finds the youngest in-flight writer of the source
// register and either forwards its stage result or flags a load-use stall.
module fwd_match
  import hazard_pkg::*;
#(
  parameter int NUM_STAGES = 3,
  parameter int AW         = 5,
  parameter int DW         = 32,
  parameter int SW         = $clog2(NUM_STAGES + 1)
) (
  input  logic [AW-1:0]               src,
  input  logic                        used,
  input  logic [DW-1:0]               rf_data,
  input  logic [NUM_STAGES*SB_EW-1:0] board,
  input  logic [NUM_STAGES*DW-1:0]    stage_data,
  output logic [SW-1:0]               sel,
  output logic [DW-1:0]               data,
  output logic                        lu_stall
);

  sb_entry_t e;
  fwd_sel_t  sel_full;
  logic      found;

  // Lowest stage index is the youngest producer, so the first hit wins.
  always_comb begin
    sel_full = FWD_RF;
    data     = rf_data;
    lu_stall = 1'b0;
    found    = 1'b0;
    e        = '0;
    if (used && (src != '0)) begin
      for (int s = 1; s <= NUM_STAGES; s++) begin
        e = sb_entry_t'(board[(s-1)*SB_EW +: SB_EW]);
        if (!found && e.valid && e.wr_en && (e.dst == SB_AW'(src))) begin
          found = 1'b1;
          if (SB_VW'(s) >= e.avail) begin
            sel_full = SB_VW'(s);
            data     = stage_data[(s-1)*DW +: DW];
          end else begin
            lu_stall = 1'b1;
          end
        end
      end
    end
  end

  assign sel = sel_full[SW-1:0];

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard and forwarding controller: in-flight destination scoreboard for E..W,
// operand forwarding, load-use stall and data-bus freeze. Optional HAZARD_STATS_EN adds perf counters.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int NUM_STAGES = 3,
  parameter int NUM_SRC    = 2,
  parameter int AW         = 5,
  parameter int DW         = 32
) (
  input  logic                                       clk,
  input  logic                                       resetn,
  input  logic                                       id_valid,
  input  logic [NUM_SRC*AW-1:0]                      id_src,
  input  logic [NUM_SRC-1:0]                         id_src_used,
  input  logic [NUM_SRC*DW-1:0]                      rf_data,
  input  logic                                       id_wr_en,
  input  logic [AW-1:0]                              id_dst,
  input  logic [$clog2(NUM_STAGES+1)-1:0]            id_avail,
  input  logic [NUM_STAGES*DW-1:0]                   stage_data,
  input  logic                                       d_busy,
  input  logic                                       flush,
  output logic [NUM_SRC*$clog2(NUM_STAGES+1)-1:0]    fwd_sel,
  output logic [NUM_SRC*DW-1:0]                      fwd_data,
  output logic                                       stall_fd,
  output logic                                       bubble_e,
  output logic                                       freeze
`ifdef HAZARD_STATS_EN
  ,
  output logic [31:0]                                perf_lu,
  output logic [31:0]                                perf_frz
`endif
);

  localparam int SW = $clog2(NUM_STAGES + 1);

  sb_entry_t                   board_q [1:NUM_STAGES];
  logic [NUM_STAGES*SB_EW-1:0] board_flat;
  logic [NUM_SRC-1:0]          lu_vec;
  logic                        lu_stall;
  sb_entry_t                   new_entry;

  for (genvar s = 1; s <= NUM_STAGES; s++) begin : g_flat
    assign board_flat[(s-1)*SB_EW +: SB_EW] = board_q[s];
  end

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    fwd_match #(
      .NUM_STAGES(NUM_STAGES),
      .AW        (AW),
      .DW        (DW),
      .SW        (SW)
    ) u_match (
      .src       (id_src[i*AW +: AW]),
      .used      (id_src_used[i]),
      .rf_data   (rf_data[i*DW +: DW]),
      .board     (board_flat),
      .stage_data(stage_data),
      .sel       (fwd_sel[i*SW +: SW]),
      .data      (fwd_data[i*DW +: DW]),
      .lu_stall  (lu_vec[i])
    );
  end

  // Stall controls depend only on the board and addresses, never on data.
  assign lu_stall = id_valid & (|lu_vec);
  assign freeze   = d_busy;
  assign stall_fd = d_busy | lu_stall;
  assign bubble_e = lu_stall & ~d_busy;

  assign new_entry = make_entry(1'b1, id_wr_en, SB_AW'(id_dst), SB_VW'(id_avail));

  // Flush beats freeze so a redirect during a bus wait still empties the board.
  always_ff @(posedge clk) begin
    if (!resetn || flush) begin
      for (int s = 1; s <= NUM_STAGES; s++) begin
        board_q[s] <= '0;
      end
    end else if (!d_busy) begin
      for (int s = NUM_STAGES; s >= 2; s--) begin
        board_q[s] <= board_q[s-1];
      end
      board_q[1] <= (lu_stall || !id_valid) ? sb_entry_t'('0) : new_entry;
    end
  end

`ifdef HAZARD_STATS_EN
  // Saturating event counters; only reset clears them.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      perf_lu  <= '0;
      perf_frz <= '0;
    end else begin
      if (bubble_e && (perf_lu != 32'hFFFF_FFFF)) begin
        perf_lu <= perf_lu + 32'd1;
      end
      if (freeze && (perf_frz != 32'hFFFF_FFFF)) begin
        perf_frz <= perf_frz + 32'd1;
      end
    end
  end
`else
  // Statistics build option absent: no counters are kept.
`endif

endmodule
